// File: rtl/bin_mult_pkg.sv
// Shared types and width helpers for the binary XNOR/AND popcount MAC stream.
package bin_mult_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bits needed to hold any count in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // Bits needed to index n entries, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin_popcount.sv
// Purely combinational population count of an N-bit vector.
module bin_popcount #(
  parameter int N = 49,
  parameter int W = 6
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(vec[i]);
    end
  end

endmodule

// File: rtl/bin_xnor_mac_stream.sv
// Streaming binary MAC: per-channel XNOR/AND against stored weights, popcount,
// accumulate NCH beats, then present count and binarised sign on valid/ready.
module bin_xnor_mac_stream
  import bin_mult_pkg::*;
#(
  parameter  int KW    = 7,
  parameter  int NCH   = 4,
  parameter  int THR   = (NCH * KW * KW + 1) / 2,
  localparam int N     = KW * KW,
  localparam int AW    = idx_width(NCH),
  localparam int P1_W  = cnt_width(KW * KW),
  localparam int ACC_W = cnt_width(NCH * KW * KW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_rst,
  input  logic             wgt_we,
  input  logic [AW-1:0]    wgt_addr,
  input  logic [N-1:0]     wgt_data,
  input  logic             img_valid,
  output logic             img_ready,
  input  logic [N-1:0]     img_data,
  input  logic             and_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_popcount,
  output logic             out_sign,
  output logic [1:0]       dbg_state
);

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and a held
  // output keeps its payload stable until the transfer edge.

  localparam logic [AW-1:0] LAST_K = AW'(NCH - 1);

  logic [N-1:0]     wgt [NCH];
  state_t           state;
  logic [AW-1:0]    k;
  logic [P1_W-1:0]  p1;
  logic             p1_v;
  logic [ACC_W-1:0] acc;
  logic [N-1:0]     masked;
  logic [P1_W-1:0]  pc;
  logic             accept;

  assign accept = img_valid && img_ready;

  // The read happens before the edge, so a same-edge write is not yet visible.
  always_comb begin
    masked = '0;
    if (and_mode) masked = img_data & wgt[k];
    else          masked = ~(img_data ^ wgt[k]);
  end

  bin_popcount #(
    .N (N),
    .W (P1_W)
  ) u_popcount (
    .vec   (masked),
    .count (pc)
  );

  // c_rst keeps the weights; only the full reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) wgt[i] <= '0;
    end else if (wgt_we && (int'(wgt_addr) < NCH)) begin
      wgt[wgt_addr] <= wgt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || c_rst) begin
      state     <= ACCUM;
      k         <= '0;
      p1        <= '0;
      p1_v      <= 1'b0;
      acc       <= '0;
      img_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      p1_v <= accept;
      if (accept) p1 <= pc;
      if (p1_v) acc <= acc + ACC_W'(p1);

      case (state)
        ACCUM: begin
          if (accept) begin
            if (k == LAST_K) begin
              k         <= '0;
              state     <= DRAIN;
              img_ready <= 1'b0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        DRAIN: begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: begin
          // p1_v is always low here, so clearing acc cannot lose a beat.
          if (out_ready) begin
            acc       <= '0;
            state     <= ACCUM;
            out_valid <= 1'b0;
            img_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          k         <= '0;
          acc       <= '0;
          img_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_popcount = out_valid ? acc : '0;
  assign out_sign     = out_valid && (acc >= ACC_W'(THR));
  assign dbg_state    = state;

endmodule
